// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - prediction queue, branch resolution and predictor update
// Fetch pushes predictions; execute pops the head in order and redirects on mispredict.
module branch_resolve_unit #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic        iCLOCK,
   input  logic        iRESET_SYNC,
   input  logic        iFLUSH,
   input  logic        iPRED_VALID,
   input  logic [31:0] iPRED_INST_ADDR,
   input  logic        iPRED_BRANCH,
   input  logic [31:0] iPRED_ADDR,
   output logic        oPRED_FULL,
   input  logic        iEXE_VALID,
   input  logic [31:0] iEXE_INST_ADDR,
   input  logic        iEXE_IS_BRANCH,
   input  logic        iEXE_TAKEN,
   input  logic [31:0] iEXE_TARGET,
   output logic        oEXE_LOCK,
   output logic        oJUMP_STB,
   output logic        oJUMP_HIT,
   output logic [31:0] oJUMP_ADDR,
   output logic [31:0] oJUMP_INST_ADDR,
   output logic        oFLUSH_PIPELINE,
   output logic [31:0] oFLUSH_ADDR,
   output logic [15:0] oBRANCH_CNT,
   output logic [15:0] oMISS_CNT
);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef struct packed {
      logic [31:0] inst_addr;
      logic        taken;
      logic [31:0] target;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   logic        jump_stb_q, jump_stb_d;
   logic        jump_hit_q, jump_hit_d;
   logic [31:0] jump_addr_q, jump_addr_d;
   logic [31:0] jump_inst_addr_q, jump_inst_addr_d;
   logic        flush_pipeline_q, flush_pipeline_d;
   logic [31:0] flush_addr_q, flush_addr_d;
   logic [15:0] branch_cnt_q, branch_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   entry_t      head;
   logic        push;
   logic        resolve;
   logic        resolve_live;
   logic        pred_taken;
   logic        act_taken;
   logic        mispredict;
   logic        update;
   logic [31:0] next_pc;

   assign oPRED_FULL = (count_q == FULL_CNT);
   assign oEXE_LOCK  = (count_q == '0);

   // A head whose address does not match the resolved instruction is treated as not-taken.
   always_comb begin
      head         = mem_q[rd_ptr_q];
      push         = iPRED_VALID && !oPRED_FULL && !flush_pipeline_q;
      resolve      = iEXE_VALID && !oEXE_LOCK;
      resolve_live = resolve && !iFLUSH;
      pred_taken   = (head.inst_addr == iEXE_INST_ADDR) && head.taken;
      act_taken    = iEXE_IS_BRANCH && iEXE_TAKEN;
      next_pc      = act_taken ? iEXE_TARGET : (iEXE_INST_ADDR + 32'd4);
      mispredict   = 1'b0;
      if (resolve_live) begin
         if (pred_taken) begin
            mispredict = !act_taken || (head.target != iEXE_TARGET);
         end else begin
            mispredict = act_taken;
         end
      end
      update = resolve_live && (iEXE_IS_BRANCH || pred_taken);
   end

   // Younger entries are wrong-path after a mispredict, so the whole queue is dropped.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (iFLUSH || mispredict) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q].inst_addr = iPRED_INST_ADDR;
            mem_d[wr_ptr_q].taken     = iPRED_BRANCH;
            mem_d[wr_ptr_q].target    = iPRED_ADDR;
            wr_ptr_d                  = wr_ptr_q + PTR_ONE;
         end
         if (resolve) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(resolve);
      end
   end

   always_comb begin
      jump_stb_d       = update;
      jump_hit_d       = update && act_taken;
      jump_addr_d      = update ? iEXE_TARGET : jump_addr_q;
      jump_inst_addr_d = update ? iEXE_INST_ADDR : jump_inst_addr_q;
      flush_pipeline_d = mispredict;
      flush_addr_d     = mispredict ? next_pc : flush_addr_q;
      branch_cnt_d     = branch_cnt_q;
      miss_cnt_d       = miss_cnt_q;
      if (resolve_live && iEXE_IS_BRANCH && (branch_cnt_q != 16'hFFFF)) begin
         branch_cnt_d = branch_cnt_q + 16'd1;
      end
      if (mispredict && (miss_cnt_q != 16'hFFFF)) begin
         miss_cnt_d = miss_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q         <= '0;
         wr_ptr_q         <= '0;
         count_q          <= '0;
         jump_stb_q       <= 1'b0;
         jump_hit_q       <= 1'b0;
         jump_addr_q      <= '0;
         jump_inst_addr_q <= '0;
         flush_pipeline_q <= 1'b0;
         flush_addr_q     <= '0;
         branch_cnt_q     <= '0;
         miss_cnt_q       <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         rd_ptr_q         <= rd_ptr_d;
         wr_ptr_q         <= wr_ptr_d;
         count_q          <= count_d;
         jump_stb_q       <= jump_stb_d;
         jump_hit_q       <= jump_hit_d;
         jump_addr_q      <= jump_addr_d;
         jump_inst_addr_q <= jump_inst_addr_d;
         flush_pipeline_q <= flush_pipeline_d;
         flush_addr_q     <= flush_addr_d;
         branch_cnt_q     <= branch_cnt_d;
         miss_cnt_q       <= miss_cnt_d;
      end
   end

   assign oJUMP_STB       = jump_stb_q;
   assign oJUMP_HIT       = jump_hit_q;
   assign oJUMP_ADDR      = jump_addr_q;
   assign oJUMP_INST_ADDR = jump_inst_addr_q;
   assign oFLUSH_PIPELINE = flush_pipeline_q;
   assign oFLUSH_ADDR     = flush_addr_q;
   assign oBRANCH_CNT     = branch_cnt_q;
   assign oMISS_CNT       = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit
// Table of single push/resolve vectors plus hand-written queue, flush and reset sequences.
module tb_branch_resolve_unit;
   localparam int DEPTH = 8;
   localparam int PTR_W = 3;
   localparam int NV    = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ext_flush = 1'b0;
   logic        pv = 1'b0;
   logic [31:0] p_inst = '0;
   logic        p_tk = 1'b0;
   logic [31:0] p_addr = '0;
   logic        pred_full;
   logic        ev = 1'b0;
   logic [31:0] e_inst = '0;
   logic        e_br = 1'b0;
   logic        e_tk = 1'b0;
   logic [31:0] e_tgt = '0;
   logic        exe_lock;
   logic        jump_stb;
   logic        jump_hit;
   logic [31:0] jump_addr;
   logic [31:0] jump_inst_addr;
   logic        flush_pipe;
   logic [31:0] flush_addr;
   logic [15:0] branch_cnt;
   logic [15:0] miss_cnt;

   always #5 clk = ~clk;

   branch_resolve_unit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(ext_flush),
      .iPRED_VALID(pv), .iPRED_INST_ADDR(p_inst), .iPRED_BRANCH(p_tk), .iPRED_ADDR(p_addr),
      .oPRED_FULL(pred_full),
      .iEXE_VALID(ev), .iEXE_INST_ADDR(e_inst), .iEXE_IS_BRANCH(e_br), .iEXE_TAKEN(e_tk),
      .iEXE_TARGET(e_tgt), .oEXE_LOCK(exe_lock),
      .oJUMP_STB(jump_stb), .oJUMP_HIT(jump_hit), .oJUMP_ADDR(jump_addr),
      .oJUMP_INST_ADDR(jump_inst_addr), .oFLUSH_PIPELINE(flush_pipe), .oFLUSH_ADDR(flush_addr),
      .oBRANCH_CNT(branch_cnt), .oMISS_CNT(miss_cnt)
   );

   typedef struct packed {
      logic        stb;
      logic        hit;
      logic [31:0] jaddr;
      logic [31:0] jinst;
      logic        fl;
      logic [31:0] faddr;
   } pulse_t;

   typedef struct {
      logic [31:0] p_inst;
      logic        p_tk;
      logic [31:0] p_addr;
      logic [31:0] e_inst;
      logic        e_br;
      logic        e_tk;
      logic [31:0] e_tgt;
      logic        x_stb;
      logic        x_hit;
      logic        x_fl;
      logic [31:0] x_faddr;
   } vec_t;

   pulse_t      sb[$];
   vec_t        vecs[NV];
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_br = '0;
   logic [15:0] exp_miss = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always @(negedge clk) begin : monitor
      pulse_t act;
      pulse_t exp_p;
      if (jump_stb === 1'b1 || flush_pipe === 1'b1) begin
         act.stb   = jump_stb;
         act.hit   = jump_stb ? jump_hit : 1'b0;
         act.jaddr = jump_stb ? jump_addr : 32'h0;
         act.jinst = jump_stb ? jump_inst_addr : 32'h0;
         act.fl    = flush_pipe;
         act.faddr = flush_pipe ? flush_addr : 32'h0;
         if (sb.size() == 0) begin
            check("unexpected_pulse", 128'(act), 128'(0));
         end else begin
            exp_p = sb.pop_front();
            check("pulse", 128'(act), 128'(exp_p));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      rst = 1'b0; ext_flush = 1'b0; pv = 1'b0; ev = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic set_push(input logic [31:0] inst, input logic tk, input logic [31:0] addr);
      pv = 1'b1; p_inst = inst; p_tk = tk; p_addr = addr;
   endtask

   task automatic set_resolve(input logic [31:0] inst, input logic br, input logic tk,
                              input logic [31:0] tgt, input logic x_stb, input logic x_hit,
                              input logic x_fl, input logic [31:0] x_faddr);
      pulse_t p;
      ev = 1'b1; e_inst = inst; e_br = br; e_tk = tk; e_tgt = tgt;
      if (br) exp_br = sat_inc(exp_br);
      if (x_fl) exp_miss = sat_inc(exp_miss);
      if (x_stb || x_fl) begin
         p.stb   = x_stb;
         p.hit   = x_hit;
         p.jaddr = x_stb ? tgt : 32'h0;
         p.jinst = x_stb ? inst : 32'h0;
         p.fl    = x_fl;
         p.faddr = x_fl ? x_faddr : 32'h0;
         sb.push_back(p);
      end
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_branch_cnt"}, 128'(branch_cnt), 128'(exp_br));
      check({tag, "_miss_cnt"}, 128'(miss_cnt), 128'(exp_miss));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_stb"}, 128'(jump_stb), 128'(0));
      check({tag, "_hit"}, 128'(jump_hit), 128'(0));
      check({tag, "_jaddr"}, 128'(jump_addr), 128'(0));
      check({tag, "_jinst"}, 128'(jump_inst_addr), 128'(0));
      check({tag, "_flush"}, 128'(flush_pipe), 128'(0));
      check({tag, "_faddr"}, 128'(flush_addr), 128'(0));
      check({tag, "_lock"}, 128'(exe_lock), 128'(1));
      check({tag, "_full"}, 128'(pred_full), 128'(0));
      check_counts(tag);
   endtask

   initial begin
      // {push inst, pred taken, pred target, exe inst, is_branch, taken, target, stb, hit, flush, flush addr}
      vecs[0] = '{32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[1] = '{32'h104, 1'b0, 32'h0,   32'h104, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 32'h300};
      vecs[2] = '{32'h108, 1'b1, 32'h400, 32'h108, 1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 1'b1, 32'h10C};
      vecs[3] = '{32'h108, 1'b1, 32'h400, 32'h108, 1'b1, 1'b1, 32'h404, 1'b1, 1'b1, 1'b1, 32'h404};
      vecs[4] = '{32'h10C, 1'b0, 32'h0,   32'h10C, 1'b1, 1'b0, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[5] = '{32'h110, 1'b1, 32'h600, 32'h110, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h114};
      vecs[6] = '{32'h114, 1'b0, 32'h0,   32'h114, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0};
      vecs[7] = '{32'h200, 1'b1, 32'h700, 32'h204, 1'b1, 1'b1, 32'h700, 1'b1, 1'b1, 1'b1, 32'h700};
      vecs[8] = '{32'h300, 1'b1, 32'h800, 32'h304, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0};
      vecs[9] = '{32'hFFFFFFFC, 1'b1, 32'h10, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 1'b1, 32'h0};

      rst = 1'b1;
      tick();
      check_reset_state("reset");

      for (int i = 0; i < NV; i++) begin
         set_push(vecs[i].p_inst, vecs[i].p_tk, vecs[i].p_addr);
         tick();
         check($sformatf("v%0d_lock_after_push", i), 128'(exe_lock), 128'(0));
         set_resolve(vecs[i].e_inst, vecs[i].e_br, vecs[i].e_tk, vecs[i].e_tgt,
                     vecs[i].x_stb, vecs[i].x_hit, vecs[i].x_fl, vecs[i].x_faddr);
         tick();
         check($sformatf("v%0d_lock_after_resolve", i), 128'(exe_lock), 128'(1));
         idle(2);
      end
      check_counts("table");

      // pushes in the mispredict cycle and while the flush pulse is high are dropped
      set_push(32'h120, 1'b0, 32'h0);
      tick();
      set_resolve(32'h120, 1'b1, 1'b1, 32'h140, 1'b1, 1'b1, 1'b1, 32'h140);
      set_push(32'h130, 1'b1, 32'h150);
      tick();
      check("drop_push_mispredict_cycle", 128'(exe_lock), 128'(1));
      set_push(32'h134, 1'b1, 32'h150);
      tick();
      check("drop_push_flush_pulse", 128'(exe_lock), 128'(1));
      set_push(32'h138, 1'b1, 32'h900);
      tick();
      check("push_after_flush", 128'(exe_lock), 128'(0));
      set_resolve(32'h138, 1'b1, 1'b1, 32'h900, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      idle(2);

      // fill to DEPTH, refused pushes, then in-order drain
      for (int i = 0; i < DEPTH; i++) begin
         set_push(32'h1000 + 32'(4 * i), 1'b1, 32'h2000 + 32'(4 * i));
         tick();
      end
      check("full_after_8", 128'(pred_full), 128'(1));
      set_push(32'h1040, 1'b1, 32'h2040);
      tick();
      check("full_after_9th", 128'(pred_full), 128'(1));
      set_resolve(32'h1000, 1'b1, 1'b1, 32'h2000, 1'b1, 1'b1, 1'b0, 32'h0);
      set_push(32'h1020, 1'b1, 32'h2020);
      tick();
      check("pop_push_full_refused", 128'(pred_full), 128'(0));
      set_push(32'h1020, 1'b1, 32'h2020);
      tick();
      check("push_after_pop", 128'(pred_full), 128'(1));
      for (int i = 1; i <= DEPTH; i++) begin
         set_resolve(32'h1000 + 32'(4 * i), 1'b1, 1'b1, 32'h2000 + 32'(4 * i),
                     1'b1, 1'b1, 1'b0, 32'h0);
         tick();
      end
      check("drained_lock", 128'(exe_lock), 128'(1));

      // 20-entry stream: push i while resolving i-1, pointers wrap repeatedly
      for (int i = 0; i <= 20; i++) begin
         if (i < 20) set_push(32'h3000 + 32'(4 * i), 1'b1, 32'h4000 + 32'(4 * i));
         if (i > 0) set_resolve(32'h3000 + 32'(4 * (i - 1)), 1'b1, 1'b1,
                                32'h4000 + 32'(4 * (i - 1)), 1'b1, 1'b1, 1'b0, 32'h0);
         tick();
      end
      check("stream_lock", 128'(exe_lock), 128'(1));
      idle(1);
      check_counts("stream");

      // resolve against an empty queue is held off
      ev = 1'b1; e_inst = 32'h5555; e_br = 1'b1; e_tk = 1'b1; e_tgt = 32'h6666;
      tick();
      check("empty_lock", 128'(exe_lock), 128'(1));
      idle(1);
      check_counts("empty");

      // external flush overrides a resolve in the same cycle
      set_push(32'h500, 1'b1, 32'h600);
      tick();
      set_push(32'h504, 1'b1, 32'h604);
      tick();
      ext_flush = 1'b1;
      ev = 1'b1; e_inst = 32'h500; e_br = 1'b1; e_tk = 1'b0; e_tgt = 32'h600;
      set_push(32'h508, 1'b1, 32'h608);
      tick();
      check("ext_flush_lock", 128'(exe_lock), 128'(1));
      idle(1);
      check_counts("ext_flush");
      set_push(32'h50C, 1'b1, 32'h60C);
      tick();
      check("push_after_ext_flush", 128'(exe_lock), 128'(0));
      set_resolve(32'h50C, 1'b1, 1'b1, 32'h60C, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      idle(2);

      // saturation: preload both counters near the top, then keep mispredicting
      force dut.branch_cnt_d = 16'hFFFE;
      force dut.miss_cnt_d = 16'hFFFD;
      tick();
      release dut.branch_cnt_d;
      release dut.miss_cnt_d;
      exp_br = 16'hFFFE;
      exp_miss = 16'hFFFD;
      check_counts("preload");
      for (int i = 0; i < 4; i++) begin
         set_push(32'h700, 1'b0, 32'h0);
         tick();
         set_resolve(32'h700, 1'b1, 1'b1, 32'h800, 1'b1, 1'b1, 1'b1, 32'h800);
         tick();
         idle(2);
      end
      check_counts("saturated");
      check("miss_cnt_ffff", 128'(miss_cnt), 128'(16'hFFFF));

      // reset in the same cycle as a mispredict: no pulse, everything cleared
      set_push(32'h900, 1'b1, 32'hA00);
      tick();
      set_push(32'h904, 1'b1, 32'hA04);
      tick();
      rst = 1'b1;
      ev = 1'b1; e_inst = 32'h900; e_br = 1'b1; e_tk = 1'b0; e_tgt = 32'hA00;
      tick();
      exp_br = '0;
      exp_miss = '0;
      check_reset_state("midreset");
      idle(1);
      check_reset_state("midreset_hold");

      set_push(32'h100, 1'b1, 32'h200);
      tick();
      set_resolve(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      idle(2);
      check_counts("after_reset");

      check("scoreboard_drained", 128'(sb.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
